// File: rtl/ptp_ts_arb_fifo.sv
// Multi-port PTP timestamp return queue: one small FIFO per MAC port, merged
// into a single output stream by a round-robin arbiter that tags the source port.
module ptp_ts_arb_fifo #(
    parameter int PORTS          = 4,
    parameter int TS_WIDTH       = 96,
    parameter int TAG_ENABLE     = 1,
    parameter int TAG_WIDTH      = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int DROP_WHEN_FULL = 0,
    parameter int PORT_WIDTH     = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PORTS*TS_WIDTH-1:0]     s_axis_ts,
    input  logic [PORTS*TAG_WIDTH-1:0]    s_axis_tag,
    input  logic [PORTS-1:0]              s_axis_valid,
    output logic [PORTS-1:0]              s_axis_ready,
    output logic [TS_WIDTH-1:0]           m_axis_ts,
    output logic [TAG_WIDTH-1:0]          m_axis_tag,
    output logic [PORT_WIDTH-1:0]         m_axis_port,
    output logic                          m_axis_valid,
    input  logic                          m_axis_ready,
    output logic [PORTS-1:0]              overflow
);

    localparam int ADDR = $clog2(FIFO_DEPTH);
    localparam logic [ADDR:0] FULL_XOR = {1'b1, {ADDR{1'b0}}};

    logic [TS_WIDTH-1:0]   tsMem  [PORTS][FIFO_DEPTH];
    logic [TAG_WIDTH-1:0]  tagMem [PORTS][FIFO_DEPTH];

    logic [ADDR:0]         wrPtr_q [PORTS];
    logic [ADDR:0]         wrPtr_d [PORTS];
    logic [ADDR:0]         rdPtr_q [PORTS];
    logic [ADDR:0]         rdPtr_d [PORTS];
    logic [PORT_WIDTH-1:0] rrPtr_q, rrPtr_d;
    logic                  mValid_q, mValid_d;
    logic [TS_WIDTH-1:0]   mTs_q, mTs_d;
    logic [TAG_WIDTH-1:0]  mTag_q, mTag_d;
    logic [PORT_WIDTH-1:0] mPort_q, mPort_d;
    logic [PORTS-1:0]      overflow_q, overflow_d;

    logic [PORTS-1:0]      fifoEmpty, fifoFull, sReady, push, drop, pop;
    logic                  hiFound, loFound, grantValid, canLoad, loadGrant;
    logic [PORT_WIDTH-1:0] hiIdx, loIdx, grantIdx, grantNext;
    logic [TS_WIDTH-1:0]   headTs;
    logic [TAG_WIDTH-1:0]  headTag;

    // A full FIFO stays closed for the whole cycle even when it is being read,
    // so readiness depends only on registered pointer state.
    always_comb begin
        fifoEmpty = '0;
        fifoFull  = '0;
        sReady    = '0;
        push      = '0;
        drop      = '0;
        for (int i = 0; i < PORTS; i++) begin
            fifoEmpty[i] = (wrPtr_q[i] == rdPtr_q[i]);
            fifoFull[i]  = ((wrPtr_q[i] ^ rdPtr_q[i]) == FULL_XOR);
            if (rst) begin
                sReady[i] = 1'b0;
            end else if (DROP_WHEN_FULL != 0) begin
                sReady[i] = 1'b1;
            end else begin
                sReady[i] = !fifoFull[i];
            end
            push[i] = s_axis_valid[i] & sReady[i] & !fifoFull[i];
            drop[i] = s_axis_valid[i] & sReady[i] & fifoFull[i];
        end
    end

    // Round robin: lowest candidate at or above the pointer wins, otherwise
    // wrap around to the lowest candidate overall.
    always_comb begin
        hiFound = 1'b0;
        loFound = 1'b0;
        hiIdx   = '0;
        loIdx   = '0;
        for (int i = PORTS - 1; i >= 0; i--) begin
            if (!fifoEmpty[i]) begin
                loFound = 1'b1;
                loIdx   = PORT_WIDTH'(i);
                if (i >= int'(rrPtr_q)) begin
                    hiFound = 1'b1;
                    hiIdx   = PORT_WIDTH'(i);
                end
            end
        end
        grantValid = hiFound | loFound;
        grantIdx   = hiFound ? hiIdx : loIdx;
        grantNext  = (grantIdx == PORT_WIDTH'(PORTS - 1)) ? '0 : grantIdx + 1'b1;
        canLoad    = !mValid_q | m_axis_ready;
        loadGrant  = canLoad & grantValid;
    end

    always_comb begin
        pop     = '0;
        headTs  = '0;
        headTag = '0;
        for (int i = 0; i < PORTS; i++) begin
            pop[i] = loadGrant && (grantIdx == PORT_WIDTH'(i));
            if (pop[i]) begin
                headTs  = tsMem[i][rdPtr_q[i][ADDR-1:0]];
                headTag = tagMem[i][rdPtr_q[i][ADDR-1:0]];
            end
        end
    end

    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        rrPtr_d    = rrPtr_q;
        mValid_d   = mValid_q;
        mTs_d      = mTs_q;
        mTag_d     = mTag_q;
        mPort_d    = mPort_q;
        overflow_d = drop;
        for (int i = 0; i < PORTS; i++) begin
            if (push[i]) begin
                wrPtr_d[i] = wrPtr_q[i] + 1'b1;
            end
            if (pop[i]) begin
                rdPtr_d[i] = rdPtr_q[i] + 1'b1;
            end
        end
        if (canLoad) begin
            mValid_d = grantValid;
            if (grantValid) begin
                mTs_d   = headTs;
                mTag_d  = (TAG_ENABLE != 0) ? headTag : '0;
                mPort_d = grantIdx;
                rrPtr_d = grantNext;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PORTS; i++) begin
                wrPtr_q[i] <= '0;
                rdPtr_q[i] <= '0;
            end
            rrPtr_q    <= '0;
            mValid_q   <= 1'b0;
            mTs_q      <= '0;
            mTag_q     <= '0;
            mPort_q    <= '0;
            overflow_q <= '0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            rrPtr_q    <= rrPtr_d;
            mValid_q   <= mValid_d;
            mTs_q      <= mTs_d;
            mTag_q     <= mTag_d;
            mPort_q    <= mPort_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is left unreset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < PORTS; i++) begin
            if (push[i]) begin
                tsMem[i][wrPtr_q[i][ADDR-1:0]]  <= s_axis_ts[i*TS_WIDTH +: TS_WIDTH];
                tagMem[i][wrPtr_q[i][ADDR-1:0]] <= s_axis_tag[i*TAG_WIDTH +: TAG_WIDTH];
            end
        end
    end

    assign s_axis_ready = sReady;
    assign m_axis_valid = mValid_q;
    assign m_axis_ts    = mTs_q;
    assign m_axis_tag   = mTag_q;
    assign m_axis_port  = mPort_q;
    assign overflow     = overflow_q;

endmodule
